mem_access_stage: RTL and testbench

- Memory stage between the EX/MEM pipeline register and the MEM/WB pipeline register of the RV32I pipelined CPU.
- Decodes the instruction held in MEM; drives the data-memory request/ack port for loads and stores, including byte/half alignment, write strobes and load sign/zero extension.
- Produces MEM_i_data and MEM_reg_wen for MEM/WB.
- Stalls the front of the pipe while memory is busy, and raises a fault on misalignment or timeout.

---
 rtl/cpu_defs_pkg.sv | 24 ++
 rtl/load_align.sv | 28 ++
 rtl/mem_access_stage.sv | 174 +++++++++++++++++
 tb/tb_mem_access_stage.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared RV32I definitions used by the memory stage: opcodes, access sizes,
// fault codes and the memory-access state encoding.
package cpu_defs_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic [1:0] FC_NONE           = 2'd0;
  localparam logic [1:0] FC_LOAD_MISALIGN  = 2'd1;
  localparam logic [1:0] FC_STORE_MISALIGN = 2'd2;
  localparam logic [1:0] FC_TIMEOUT        = 2'd3;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/half lane out of a read word and sign- or
// zero-extends it to XLEN bits.
module load_align (
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] rdata,
  output logic [31:0] result
);
  import cpu_defs_pkg::*;

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = rdata[{addr_lo, 3'b000} +: 8];
    half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    result    = rdata;
    case (size)
      SIZE_BYTE: result = is_unsigned ? {24'h0, byte_lane}
                                      : {{24{byte_lane[7]}}, byte_lane};
      SIZE_HALF: result = is_unsigned ? {16'h0, half_lane}
                                      : {{16{half_lane[15]}}, half_lane};
      default:   result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// RV32I MEM stage: drives the data-memory port for loads/stores, stalls the
// front of the pipe while the access is outstanding and flags faults.
module mem_access_stage
  import cpu_defs_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] MEM_inst,
  input  logic [31:0] MEM_alu_result,
  input  logic [31:0] MEM_rs2_data,
  input  logic        MEM_reg_wen_in,
  output logic [31:0] MEM_i_data,
  output logic        MEM_reg_wen,
  output logic        stall,
  output logic        mem_fault,
  output logic [1:0]  fault_cause,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata
);

  // Last WAIT count at which an ack is still accepted; bounds total stall to TIMEOUT cycles.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 2);

  mem_state_t       state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             fault_set;
  logic [1:0]       fault_code;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [1:0]  size;
  logic [1:0]  addr_lo;
  logic        is_load, is_store, is_mem, misaligned, squash;
  logic [31:0] load_data;
  logic        unused_inst;

  assign opcode      = MEM_inst[6:0];
  assign funct3      = MEM_inst[14:12];
  assign size        = funct3[1:0];
  assign addr_lo     = MEM_alu_result[1:0];
  assign is_load     = (opcode == OPC_LOAD);
  assign is_store    = (opcode == OPC_STORE);
  assign is_mem      = is_load || is_store;
  assign unused_inst = ^{MEM_inst[31:15], MEM_inst[11:7]};

  // The instruction that just timed out is still frozen in MEM; let it drain without re-requesting.
  assign squash = mem_fault && (fault_cause == FC_TIMEOUT);

  always_comb begin
    case (size)
      SIZE_BYTE: misaligned = 1'b0;
      SIZE_HALF: misaligned = addr_lo[0];
      SIZE_WORD: misaligned = (addr_lo != 2'b00);
      default:   misaligned = 1'b1;
    endcase
  end

  load_align u_load_align (
    .addr_lo     (addr_lo),
    .size        (size),
    .is_unsigned (funct3[2]),
    .rdata       (dmem_rdata),
    .result      (load_data)
  );

  // Store lane placement and word-aligned address.
  always_comb begin
    dmem_addr  = {MEM_alu_result[31:2], 2'b00};
    dmem_wdata = MEM_rs2_data;
    dmem_wstrb = 4'b0000;
    if (is_store) begin
      case (size)
        SIZE_BYTE: begin
          dmem_wdata = {4{MEM_rs2_data[7:0]}};
          dmem_wstrb = 4'b0001 << addr_lo;
        end
        SIZE_HALF: begin
          dmem_wdata = {2{MEM_rs2_data[15:0]}};
          dmem_wstrb = 4'b0011 << addr_lo;
        end
        default: begin
          dmem_wdata = MEM_rs2_data;
          dmem_wstrb = 4'b1111;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      mem_fault   <= 1'b0;
      fault_cause <= FC_NONE;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      mem_fault   <= fault_set;
      fault_cause <= fault_set ? fault_code : FC_NONE;
    end
  end

  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    fault_set   = 1'b0;
    fault_code  = FC_NONE;
    MEM_i_data  = MEM_alu_result;
    MEM_reg_wen = MEM_reg_wen_in;
    stall       = 1'b0;
    dmem_req    = 1'b0;

    case (state)
      IDLE: begin
        if (squash) begin
          MEM_reg_wen = 1'b0;
        end else if (is_mem && misaligned) begin
          MEM_reg_wen = 1'b0;
          fault_set   = 1'b1;
          fault_code  = is_load ? FC_LOAD_MISALIGN : FC_STORE_MISALIGN;
        end else if (is_mem) begin
          dmem_req = 1'b1;
          if (dmem_ack) begin
            if (is_load) MEM_i_data = load_data;
            else         MEM_reg_wen = 1'b0;
          end else begin
            stall       = 1'b1;
            MEM_reg_wen = 1'b0;
            cnt_next    = '0;
            state_next  = WAIT;
          end
        end
      end

      WAIT: begin
        dmem_req = 1'b1;
        cnt_next = cnt + CNT_W'(1);
        if (dmem_ack) begin
          state_next = IDLE;
          if (is_load) MEM_i_data = load_data;
          else         MEM_reg_wen = 1'b0;
        end else begin
          stall       = 1'b1;
          MEM_reg_wen = 1'b0;
          if (cnt == CNT_LAST) begin
            fault_set  = 1'b1;
            fault_code = FC_TIMEOUT;
            state_next = IDLE;
          end
        end
      end

      default: state_next = IDLE;
    endcase

    if (rst) begin
      stall       = 1'b0;
      dmem_req    = 1'b0;
      MEM_reg_wen = 1'b0;
      fault_set   = 1'b0;
    end
  end

  assign dmem_we = is_store && dmem_req;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: zero-wait vector table through a
// scoreboard queue, plus wait/timeout/misalign/reset sequences.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] MEM_inst, MEM_alu_result, MEM_rs2_data;
  logic        MEM_reg_wen_in;
  logic [31:0] MEM_i_data;
  logic        MEM_reg_wen, stall, mem_fault;
  logic [1:0]  fault_cause;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk            (clk),
    .rst            (rst),
    .MEM_inst       (MEM_inst),
    .MEM_alu_result (MEM_alu_result),
    .MEM_rs2_data   (MEM_rs2_data),
    .MEM_reg_wen_in (MEM_reg_wen_in),
    .MEM_i_data     (MEM_i_data),
    .MEM_reg_wen    (MEM_reg_wen),
    .stall          (stall),
    .mem_fault      (mem_fault),
    .fault_cause    (fault_cause),
    .dmem_req       (dmem_req),
    .dmem_we        (dmem_we),
    .dmem_addr      (dmem_addr),
    .dmem_wdata     (dmem_wdata),
    .dmem_wstrb     (dmem_wstrb),
    .dmem_ack       (dmem_ack),
    .dmem_rdata     (dmem_rdata)
  );

  typedef struct {
    string       name;
    logic [31:0] inst, alu, rs2, rdata;
    logic        wen_in, ack;
    logic        chk_data;
    logic [31:0] e_data;
    logic        e_wen, e_stall, e_req, e_we;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_wstrb;
    logic        chk_wdata;
  } vec_t;

  vec_t vecs[$];
  vec_t sb_q[$];
  vec_t e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] opc, input logic [2:0] f3);
    return {17'h0, f3, 5'd5, opc};
  endfunction

  task automatic drive(input logic [31:0] inst, input logic [31:0] alu, input logic [31:0] rs2,
                       input logic [31:0] rdata, input logic wen_in, input logic ack);
    MEM_inst       = inst;
    MEM_alu_result = alu;
    MEM_rs2_data   = rs2;
    dmem_rdata     = rdata;
    MEM_reg_wen_in = wen_in;
    dmem_ack       = ack;
  endtask

  task automatic add_vec(input string name, input logic [31:0] inst, input logic [31:0] alu,
                         input logic [31:0] rs2, input logic [31:0] rdata, input logic wen_in,
                         input logic ack, input logic chk_data, input logic [31:0] e_data,
                         input logic e_wen, input logic e_req, input logic e_we,
                         input logic [31:0] e_addr, input logic [31:0] e_wdata,
                         input logic [3:0] e_wstrb, input logic chk_wdata);
    vec_t v;
    v.name = name; v.inst = inst; v.alu = alu; v.rs2 = rs2; v.rdata = rdata;
    v.wen_in = wen_in; v.ack = ack; v.chk_data = chk_data; v.e_data = e_data;
    v.e_wen = e_wen; v.e_stall = 1'b0; v.e_req = e_req; v.e_we = e_we;
    v.e_addr = e_addr; v.e_wdata = e_wdata; v.e_wstrb = e_wstrb; v.chk_wdata = chk_wdata;
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int stall_cnt;
    logic [31:0] nop;
    nop = mk(7'h13, 3'd0);

    // zero-wait vectors: name, inst, alu, rs2, rdata, wen_in, ack | expected
    add_vec("addi",  mk(7'h13,3'd0), 32'h0000_1234, 32'h0, 32'h0, 1'b1, 1'b0,
            1'b1, 32'h0000_1234, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    add_vec("lb",    mk(7'h03,3'd0), 32'h0000_0103, 32'h0, 32'h80FF_0000, 1'b1, 1'b1,
            1'b1, 32'hFFFF_FF80, 1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'h0, 1'b0);
    add_vec("lbu",   mk(7'h03,3'd4), 32'h0000_0103, 32'h0, 32'h80FF_0000, 1'b1, 1'b1,
            1'b1, 32'h0000_0080, 1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'h0, 1'b0);
    add_vec("lh",    mk(7'h03,3'd1), 32'h0000_0102, 32'h0, 32'h80FF_0000, 1'b1, 1'b1,
            1'b1, 32'hFFFF_80FF, 1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'h0, 1'b0);
    add_vec("lhu",   mk(7'h03,3'd5), 32'h0000_0102, 32'h0, 32'h80FF_0000, 1'b1, 1'b1,
            1'b1, 32'h0000_80FF, 1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'h0, 1'b0);
    add_vec("lb1",   mk(7'h03,3'd0), 32'h0000_0101, 32'h0, 32'h0000_7F00, 1'b1, 1'b1,
            1'b1, 32'h0000_007F, 1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'h0, 1'b0);
    add_vec("lw",    mk(7'h03,3'd2), 32'h0000_0200, 32'h0, 32'h1234_5678, 1'b0, 1'b1,
            1'b1, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 32'h0000_0200, 32'h0, 4'h0, 1'b0);
    add_vec("sb",    mk(7'h23,3'd0), 32'h0000_0101, 32'h1122_3344, 32'h0, 1'b1, 1'b1,
            1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0000_0100, 32'h4444_4444, 4'b0010, 1'b1);
    add_vec("sb3",   mk(7'h23,3'd0), 32'h0000_0203, 32'h0000_00AB, 32'h0, 1'b1, 1'b1,
            1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0000_0200, 32'hABAB_ABAB, 4'b1000, 1'b1);
    add_vec("sh",    mk(7'h23,3'd1), 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 1'b1, 1'b1,
            1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0000_0100, 32'hBEEF_BEEF, 4'b0011, 1'b1);
    add_vec("sw",    mk(7'h23,3'd2), 32'h0000_0300, 32'hCAFE_F00D, 32'h0, 1'b1, 1'b1,
            1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0000_0300, 32'hCAFE_F00D, 4'b1111, 1'b1);
    add_vec("add_nw", mk(7'h33,3'd0), 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b0, 1'b0,
            1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);

    // reset
    rst = 1'b1;
    drive(nop, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_fault", mem_fault, 1'b0);
    chk("rst_cause", fault_cause, 2'd0);
    chk("rst_req", dmem_req, 1'b0);
    chk("rst_stall", stall, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // zero-wait table through the scoreboard
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].inst, vecs[i].alu, vecs[i].rs2, vecs[i].rdata, vecs[i].wen_in, vecs[i].ack);
      sb_q.push_back(vecs[i]);
      #1;
      e = sb_q.pop_front();
      chk({e.name, "_stall"}, stall, e.e_stall);
      chk({e.name, "_req"}, dmem_req, e.e_req);
      chk({e.name, "_wen"}, MEM_reg_wen, e.e_wen);
      chk({e.name, "_fault"}, mem_fault, 1'b0);
      if (e.chk_data) chk({e.name, "_data"}, MEM_i_data, e.e_data);
      if (e.e_req) begin
        chk({e.name, "_addr"}, dmem_addr, e.e_addr);
        chk({e.name, "_we"}, dmem_we, e.e_we);
        chk({e.name, "_wstrb"}, dmem_wstrb, e.e_wstrb);
      end
      if (e.chk_wdata) chk({e.name, "_wdata"}, dmem_wdata, e.e_wdata);
    end

    // SH with ack after 3 stall cycles
    @(negedge clk);
    drive(mk(7'h23,3'd1), 32'h0000_0102, 32'hDEAD_BEEF, 32'h0, 1'b1, 1'b0);
    stall_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge clk);
      dmem_ack = (c == 3);
      #1;
      chk("shw_req", dmem_req, 1'b1);
      chk("shw_wen", MEM_reg_wen, 1'b0);
      chk("shw_wstrb", dmem_wstrb, 4'b1100);
      chk("shw_wdata", dmem_wdata, 32'hBEEF_BEEF);
      chk("shw_addr", dmem_addr, 32'h0000_0100);
      if (!stall) break;
      stall_cnt++;
    end
    chk("shw_stall_cycles", stall_cnt, 3);
    @(negedge clk);
    drive(nop, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("shw_after_req", dmem_req, 1'b0);
    chk("shw_after_fault", mem_fault, 1'b0);

    // misaligned LW, SH and size 11
    @(negedge clk);
    drive(mk(7'h03,3'd2), 32'h0000_0201, 32'h0, 32'h0, 1'b1, 1'b0);
    #1;
    chk("mlw_req", dmem_req, 1'b0);
    chk("mlw_stall", stall, 1'b0);
    chk("mlw_wen", MEM_reg_wen, 1'b0);
    @(negedge clk);
    drive(mk(7'h23,3'd1), 32'h0000_0103, 32'h1, 32'h0, 1'b1, 1'b0);
    #1;
    chk("mlw_fault", mem_fault, 1'b1);
    chk("mlw_cause", fault_cause, 2'd1);
    chk("msh_req", dmem_req, 1'b0);
    @(negedge clk);
    drive(mk(7'h03,3'd3), 32'h0000_0200, 32'h0, 32'h0, 1'b1, 1'b1);
    #1;
    chk("msh_fault", mem_fault, 1'b1);
    chk("msh_cause", fault_cause, 2'd2);
    chk("m11_req", dmem_req, 1'b0);
    @(negedge clk);
    drive(nop, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("m11_cause", fault_cause, 2'd1);
    @(negedge clk);
    #1;
    chk("m_clear", mem_fault, 1'b0);

    // LW never acked: timeout
    @(negedge clk);
    drive(mk(7'h03,3'd2), 32'h0000_0400, 32'h0, 32'h0, 1'b1, 1'b0);
    stall_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (!stall) break;
      chk("to_wen", MEM_reg_wen, 1'b0);
      chk("to_req", dmem_req, 1'b1);
      stall_cnt++;
    end
    chk("to_stall_cycles", stall_cnt, 16);
    chk("to_drop_req", dmem_req, 1'b0);
    chk("to_fault", mem_fault, 1'b1);
    chk("to_cause", fault_cause, 2'd3);
    chk("to_end_wen", MEM_reg_wen, 1'b0);
    @(negedge clk);
    drive(nop, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("to_clear", mem_fault, 1'b0);

    // ack lands in the timeout cycle and wins
    @(negedge clk);
    drive(mk(7'h03,3'd2), 32'h0000_0404, 32'h0, 32'hA5A5_0001, 1'b1, 1'b0);
    stall_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) @(negedge clk);
      dmem_ack = (c == 15);
      #1;
      if (!stall) break;
      stall_cnt++;
    end
    chk("late_stall_cycles", stall_cnt, 15);
    chk("late_data", MEM_i_data, 32'hA5A5_0001);
    chk("late_wen", MEM_reg_wen, 1'b1);
    @(negedge clk);
    drive(nop, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("late_fault", mem_fault, 1'b0);

    // reset in the middle of WAIT
    @(negedge clk);
    drive(mk(7'h03,3'd2), 32'h0000_0500, 32'h0, 32'h0, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    chk("rw_stall", stall, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    drive(nop, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rw_req", dmem_req, 1'b0);
    chk("rw_stall0", stall, 1'b0);
    chk("rw_fault", mem_fault, 1'b0);
    @(negedge clk);
    drive(mk(7'h03,3'd0), 32'h0000_0103, 32'h0, 32'h80FF_0000, 1'b1, 1'b1);
    #1;
    chk("rw_lb_stall", stall, 1'b0);
    chk("rw_lb_data", MEM_i_data, 32'hFFFF_FF80);
    chk("rw_lb_fault", mem_fault, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
